// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_reg elastic register pipeline.
package pipe_pkg;

   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 64;
   localparam int DEPTH_MIN = 1;
   localparam int DEPTH_MAX = 16;

   // Bits needed to hold an occupancy of 0..depth.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: valid flag plus data register, loaded only when a new entry arrives.
// Scan shifting through the data register is present only when PIPE_REG_SCAN_EN is defined.
module pipe_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             flush,
   input  logic             load,
   input  logic             drain,
`ifdef PIPE_REG_SCAN_EN
   input  logic             se,
   input  logic             si,
   output logic             so,
`endif
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             v,
   output logic             v_nxt
);

   // An entry stays unless it drains downstream; a fresh load always marks the stage valid.
   always_comb v_nxt = flush ? 1'b0 : (load | (v & ~drain));

`ifdef PIPE_REG_SCAN_EN
   logic [WIDTH-1:0] shifted;

   always_comb begin
      shifted    = q << 1;
      shifted[0] = si;
   end

   assign so = q[WIDTH-1];
`endif

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         v <= 1'b0;
         q <= '0;
      end else begin
         v <= v_nxt;
`ifdef PIPE_REG_SCAN_EN
         if (se)
            q <= shifted;
         else
`endif
         if (load)
            q <= d;
      end
   end

endmodule

// File: rtl/pipe_reg.sv
// Elastic valid/ready register pipeline with bubble collapsing, flush and registered occupancy.
// Optional scan chain through all data bits when PIPE_REG_SCAN_EN is defined.
module pipe_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                      CK,
   input  logic                      RN,
   input  logic                      FLUSH,
   input  logic                      IN_VALID,
   output logic                      IN_READY,
   input  logic [WIDTH-1:0]          D,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY,
   output logic [WIDTH-1:0]          Q,
   output logic [WIDTH-1:0]          QN,
   output logic [cnt_w(DEPTH)-1:0]   COUNT
`ifdef PIPE_REG_SCAN_EN
   ,
   input  logic                      SE,
   input  logic                      SI,
   output logic                      SO
`endif
);

   localparam int CW = cnt_w(DEPTH);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_param
      $error("pipe_reg: WIDTH or DEPTH out of range");
   end

   logic                 hold;
   logic [DEPTH-1:0]     v;
   logic [DEPTH-1:0]     v_nxt;
   logic [DEPTH-1:0]     load;
   logic [DEPTH-1:0]     drain;
   logic [DEPTH:0]       rdy;
   logic [WIDTH-1:0]     dq [DEPTH];
   logic [CW-1:0]        cnt_nxt;

`ifdef PIPE_REG_SCAN_EN
   logic [DEPTH-1:0]     so_w;
   assign hold = SE;
   assign SO   = so_w[DEPTH-1];
`else
   assign hold = 1'b0;
`endif

   // Stage k can take an entry if it or any stage downstream of it is empty, or the sink pops.
   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = OUT_READY & ~hold;
      for (int k = 0; k < DEPTH; k++) begin
         rdy[k] = OUT_READY & ~hold;
         for (int j = k; j < DEPTH; j++) begin
            if (!v[j])
               rdy[k] = 1'b1;
         end
      end
   end

   assign IN_READY  = rdy[0] & ~FLUSH & ~hold;
   assign OUT_VALID = v[DEPTH-1] & ~FLUSH & ~hold;
   assign Q         = dq[DEPTH-1];
   assign QN        = ~Q;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [WIDTH-1:0] d_in;

      if (k == 0) begin : g_first
         assign load[k] = IN_VALID & IN_READY;
         assign d_in    = D;
      end else begin : g_next
         assign load[k] = v[k-1] & rdy[k] & ~FLUSH & ~hold;
         assign d_in    = dq[k-1];
      end

      assign drain[k] = rdy[k+1] & ~hold;

`ifdef PIPE_REG_SCAN_EN
      logic si_in;
      if (k == 0) begin : g_si_first
         assign si_in = SI;
      end else begin : g_si_next
         assign si_in = so_w[k-1];
      end
`endif

      pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk   (CK),
         .rst_b (RN),
         .flush (FLUSH),
         .load  (load[k]),
         .drain (drain[k]),
`ifdef PIPE_REG_SCAN_EN
         .se    (SE),
         .si    (si_in),
         .so    (so_w[k]),
`endif
         .d     (d_in),
         .q     (dq[k]),
         .v     (v[k]),
         .v_nxt (v_nxt[k])
      );
   end

   always_comb begin
      cnt_nxt = '0;
      for (int k = 0; k < DEPTH; k++)
         cnt_nxt = cnt_nxt + CW'(v_nxt[k]);
   end

   always_ff @(posedge CK) begin
      if (!RN)
         COUNT <= '0;
      else
         COUNT <= cnt_nxt;
   end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per stage, 1..64.
REQ-002 SHALL have parameter DEPTH, default 2: number of register stages, 1..16.
REQ-003 SHALL have port CK  input  1: sole clock, rising-edge active.
REQ-004 SHALL have port RN  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port FLUSH  input  1: discards all held entries.
REQ-006 SHALL have port IN_VALID  input  1: upstream presents D.
REQ-007 SHALL have port IN_READY  output  1: pipe accepts D this cycle.
REQ-008 SHALL have port D  input  WIDTH: write data.
REQ-009 SHALL have port OUT_VALID  output  1: Q holds a valid entry.
REQ-010 SHALL have port OUT_READY  input  1: downstream consumes Q.
REQ-011 SHALL have port Q  output  WIDTH: last-stage data.
REQ-012 SHALL have port QN  output  WIDTH: bitwise inverse of Q, always.
REQ-013 SHALL have port COUNT  output  clog2(DEPTH+1): number of valid stages.

Function
REQ-014 SHALL hold per stage k (0 = input side, DEPTH-1 = output side) one WIDTH data register and one valid flag v[k].
REQ-015 SHALL compute stage readiness rdy[k] = !v[k] | rdy[k+1], with rdy[DEPTH] = OUT_READY; IN_READY = rdy[0] & !FLUSH.
REQ-016 SHALL accept D into stage 0 when IN_VALID & IN_READY; stage k SHALL load stage k-1 when v[k-1] & rdy[k].
REQ-017 SHALL collapse bubbles: an entry advances whenever the next stage is empty or advancing in the same cycle.
REQ-018 SHALL deliver an entry accepted at edge t on Q with OUT_VALID=1 after edge t+DEPTH-1 when OUT_READY is held high (latency DEPTH cycles, throughput 1/cycle).
REQ-019 SHALL preserve order; no entry dropped or duplicated except via FLUSH.
REQ-020 SHALL keep Q and v[DEPTH-1] unchanged while OUT_VALID & !OUT_READY (stall); a full pipe SHALL drive IN_READY=0 unless OUT_READY=1.
REQ-021 SHALL, when full and OUT_READY & IN_VALID both high, pop and push in the same cycle with COUNT unchanged.
REQ-022 SHALL, on FLUSH=1, force OUT_VALID=0 and IN_READY=0 that cycle and clear all v[k] at the edge; data registers SHALL hold.
REQ-023 SHALL register COUNT as the popcount of v[], updated every edge.
REQ-024 SHALL NOT load data registers whose valid flag is not being set (low-power hold).

Reset
REQ-025 SHALL, on the edge where RN=0, clear all v[k], all data registers and COUNT; after reset Q=0, QN=all ones, OUT_VALID=0, COUNT=0.
REQ-026 SHALL give RN priority over FLUSH, scan and handshakes; reset mid-transfer discards all entries.

Configuration
REQ-027 SHALL, with PIPE_REG_SCAN_EN defined, add ports SE input 1, SI input 1, SO output 1, chaining all data bits SI -> stage0 bit0 .. stage DEPTH-1 bit WIDTH-1 -> SO.
REQ-028 SHALL, while SE=1, shift the chain one bit per edge, hold all v[k], and force IN_READY=0 and OUT_VALID=0.
REQ-029 SHALL, without PIPE_REG_SCAN_EN, have no SE/SI/SO ports and no scan muxing.

Structure
REQ-030 SHALL place the COUNT-width constant function and WIDTH/DEPTH limit constants in shared package pipe_pkg.
REQ-031 SHALL implement one stage as sub-module pipe_stage (valid flag, data register, load enable, scan mux), instantiated DEPTH times.

Verification
REQ-032 WIDTH=8 DEPTH=3, OUT_READY=1, push 0x11,0x22,0x33 on consecutive cycles -> Q=0x11,0x22,0x33 on cycles 3,4,5, QN=0xEE,0xDD,0xCC.
REQ-033 OUT_READY=0, push 4 entries -> first 3 accepted, IN_READY=0 on 4th, COUNT=3; then OUT_READY=1 -> 0x11 popped, 4th accepted same cycle, COUNT stays 3.
REQ-034 Push 0xA5, gap, 0x5A with OUT_READY=0 then release -> no bubble on Q, outputs 0xA5,0x5A back-to-back.
REQ-035 COUNT=2, assert FLUSH with IN_VALID=1 -> IN_READY=0, OUT_VALID=0, next cycle COUNT=0, Q unchanged.
REQ-036 RN=0 for one edge while full and stalled -> OUT_VALID=0, Q=0x00, QN=0xFF, COUNT=0 next cycle.
REQ-037 PIPE_REG_SCAN_EN, SE=1, shift 24 bits of 0xC3_96_5A pattern -> SO reproduces it after 24 edges, v[] unchanged.
